// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory fetch controller
package imem_pkg;
   typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_HALT} state_e;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_t;
   localparam logic [31:0] NOP_INSTR  = 32'h0000000D;
   localparam logic [1:0]  ALIGN_BITS = 2'b00;
   function automatic logic [29:0] word_idx(input logic [31:0] a);
      return a[31:2];
   endfunction
endpackage

// File: rtl/imem_fetch_fifo2.sv
// fetch_fifo2: 2-entry skid FIFO holding {pc, instr}; flush wins over push/pop
module fetch_fifo2
   import imem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_flush,
   input  fetch_t     i_din,
   output fetch_t     o_dout,
   output logic [1:0] o_count
);
   fetch_t     r_mem [2];
   logic       r_rd;
   logic       r_wr;
   logic [1:0] r_cnt;
   logic       w_pop;
   logic       w_push;
   assign w_pop   = i_pop && r_cnt != 2'd0;
   assign w_push  = i_push && (r_cnt != 2'd2 || w_pop);
   assign o_count = r_cnt;
   assign o_dout  = r_cnt != 2'd0 ? r_mem[r_rd] : '0;
   always_ff @(posedge clk) begin
      if (w_push && !i_flush)
         r_mem[r_wr] <= i_din;
   end
   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_rd  <= 1'b0;
         r_wr  <= 1'b0;
         r_cnt <= 2'd0;
      end else begin
         r_rd  <= r_rd ^ w_pop;
         r_wr  <= r_wr ^ w_push;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: shares the imem port between the loader and the fetch path,
// generates the PC stream and hands buffered words to decode.
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 128,
   parameter logic [31:0] RESET_PC    = 32'h0
)(
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_rdata,
   output logic        o_imem_we,
   output logic [31:0] o_imem_waddr,
   output logic [31:0] o_imem_wdata,
   input  logic        i_ld_start,
   input  logic        i_ld_valid,
   input  logic [31:0] i_ld_addr,
   input  logic [31:0] i_ld_data,
   input  logic        i_ld_done,
   output logic        o_ld_ready,
   output logic        o_if_valid,
   input  logic        i_if_ready,
   output logic [31:0] o_if_instr,
   output logic [31:0] o_if_pc,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_halted,
   output logic        o_fault
);
   state_e      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic        r_fault, w_fault_nxt;
   logic        w_flush, w_push, w_pop, w_slot;
   logic [1:0]  w_count;
   fetch_t      w_head;
   function automatic logic addr_ok(input logic [31:0] a);
      return a[1:0] == ALIGN_BITS && {2'b00, word_idx(a)} < DEPTH_WORDS;
   endfunction
   assign w_pop  = o_if_valid && i_if_ready;
   assign w_slot = w_count != 2'd2 || w_pop;
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_fault_nxt = r_fault;
      w_flush     = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         ST_LOAD: if (i_ld_done) begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = RESET_PC;
            w_flush     = 1'b1;
         end
         ST_RUN: if (i_ld_start) begin
            w_state_nxt = ST_LOAD;
            w_flush     = 1'b1;
         end else if (i_redirect_valid) begin
            w_pc_nxt = i_redirect_pc;
            w_flush  = 1'b1;
         end else if (w_slot && !addr_ok(r_pc)) begin
            w_state_nxt = ST_HALT;
            w_fault_nxt = 1'b1;
         end else if (w_slot) begin
            w_push   = 1'b1;
            w_pc_nxt = r_pc + 32'd4;
         end
         ST_HALT: if (i_ld_start) begin
            w_state_nxt = ST_LOAD;
            w_fault_nxt = 1'b0;
            w_flush     = 1'b1;
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_LOAD;
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_fault <= w_fault_nxt;
      end
   end
   fetch_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_din   ('{pc: r_pc, instr: i_imem_rdata}),
      .o_dout  (w_head),
      .o_count (w_count)
   );
   assign o_imem_addr  = r_pc;
   assign o_imem_we    = rst_n && r_state == ST_LOAD && i_ld_valid && addr_ok(i_ld_addr);
   assign o_imem_waddr = i_ld_addr;
   assign o_imem_wdata = i_ld_data;
   assign o_ld_ready   = rst_n && r_state == ST_LOAD;
   assign o_if_valid   = w_count != 2'd0;
   assign o_if_instr   = w_head.instr;
   assign o_if_pc      = w_head.pc;
   assign o_halted     = r_state == ST_HALT;
   assign o_fault      = r_fault;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed and randomized checks of the fetch controller
// against an in-order PC/instruction reference model.
module tb_imem_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr, imem_rdata, imem_waddr, imem_wdata;
   logic        imem_we;
   logic        ld_start, ld_valid, ld_done, ld_ready;
   logic [31:0] ld_addr, ld_data;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted, fault;
   logic [31:0] mem  [128];
   logic [31:0] mref [128];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   imem_fetch_ctrl #(.DEPTH_WORDS(128), .RESET_PC(32'h0)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .o_imem_addr      (imem_addr),
      .i_imem_rdata     (imem_rdata),
      .o_imem_we        (imem_we),
      .o_imem_waddr     (imem_waddr),
      .o_imem_wdata     (imem_wdata),
      .i_ld_start       (ld_start),
      .i_ld_valid       (ld_valid),
      .i_ld_addr        (ld_addr),
      .i_ld_data        (ld_data),
      .i_ld_done        (ld_done),
      .o_ld_ready       (ld_ready),
      .o_if_valid       (if_valid),
      .i_if_ready       (if_ready),
      .o_if_instr       (if_instr),
      .o_if_pc          (if_pc),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_halted         (halted),
      .o_fault          (fault)
   );

   assign imem_rdata = mem[imem_addr[8:2]];
   always @(posedge clk) if (imem_we) mem[imem_waddr[8:2]] <= imem_wdata;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run();
      ld_done = 1'b1;
      step();
      ld_done = 1'b0;
   endtask

   task automatic to_load();
      redirect_valid = 1'b0;
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'hDEAD_BEEF;
      step(); step(); #1;
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid: got %b exp 0", if_valid); end
      n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b exp 0", imem_we); end
      n_vec++; if (halted !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL reset_halt_fault: got %b%b exp 00", halted, fault); end
      n_vec++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin n_err++; $display("FAIL reset_head: got %h/%h exp 0/0", if_pc, if_instr); end
      rst_n = 1'b1; ld_valid = 1'b0;
      step(); #1;
      n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready: got %b exp 1", ld_ready); end
   endtask

   task automatic test_load();
      for (int i = 0; i < 128; i++) begin
         ld_valid = 1'b1; ld_addr = i * 4; ld_data = $urandom;
         #1;
         n_vec++; if (imem_we !== 1'b1 || imem_waddr !== ld_addr || imem_wdata !== ld_data) begin
            n_err++; $display("FAIL load_write[%0d]: got we=%b %h/%h exp 1 %h/%h", i, imem_we, imem_waddr, imem_wdata, ld_addr, ld_data);
         end
         mref[i] = ld_data;
         step();
      end
      ld_addr = 32'h3; ld_data = 32'h1111_1111; #1;
      n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL load_misaligned: got we=%b exp 0", imem_we); end
      step();
      ld_addr = 32'h400; ld_data = 32'h2222_2222; #1;
      n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL load_range: got we=%b exp 0", imem_we); end
      step();
      ld_valid = 1'b0; ld_start = 1'b1;
      step();
      ld_start = 1'b0; #1;
      n_vec++; if (ld_ready !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL ld_start_in_load: got ready=%b halted=%b exp 1 0", ld_ready, halted); end
   endtask

   task automatic test_run_seq();
      if_ready = 1'b1;
      start_run(); #1;
      n_vec++; if (if_valid !== 1'b0 || ld_ready !== 1'b0) begin n_err++; $display("FAIL run_first: got valid=%b ready=%b exp 0 0", if_valid, ld_ready); end
      step();
      for (int k = 0; k < 4; k++) begin
         #1;
         n_vec++; if (if_valid !== 1'b1 || if_pc !== k * 4 || if_instr !== mref[k]) begin
            n_err++; $display("FAIL run_seq[%0d]: got v=%b %h/%h exp 1 %h/%h", k, if_valid, if_pc, if_instr, k * 4, mref[k]);
         end
         step();
      end
      to_load(); #1;
      n_vec++; if (ld_ready !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL run_to_load: got ready=%b valid=%b exp 1 0", ld_ready, if_valid); end
   endtask

   task automatic test_stall();
      if_ready = 1'b0;
      start_run(); step();
      for (int k = 0; k < 4; k++) begin
         #1;
         n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mref[0]) begin
            n_err++; $display("FAIL stall_hold[%0d]: got v=%b %h/%h exp 1 0/%h", k, if_valid, if_pc, if_instr, mref[0]);
         end
         step();
      end
      #1;
      n_vec++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_fetch_pc: got %h exp 8", imem_addr); end
      if_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_vec++; if (if_valid !== 1'b1 || if_pc !== k * 4 || if_instr !== mref[k]) begin
            n_err++; $display("FAIL stall_release[%0d]: got v=%b %h exp 1 %h", k, if_valid, if_pc, k * 4);
         end
         step();
      end
      if_ready = 1'b0;
      to_load();
   endtask

   task automatic test_redirect();
      if_ready = 1'b0;
      start_run(); step(); step();
      if_ready = 1'b1; #1;
      n_vec++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL redir_pre0: got %h exp 0", if_pc); end
      step();
      if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin n_err++; $display("FAIL redir_head: got v=%b %h exp 1 4", if_valid, if_pc); end
      step();
      redirect_valid = 1'b0; #1;
      n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble: got %b exp 0", if_valid); end
      step(); #1;
      n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== mref[16]) begin
         n_err++; $display("FAIL redir_target: got v=%b %h/%h exp 1 40/%h", if_valid, if_pc, if_instr, mref[16]);
      end
   endtask

   task automatic test_fault();
      redirect_valid = 1'b1; redirect_pc = 32'h42;
      step();
      redirect_valid = 1'b0; #1;
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL fault_early: got halted=%b exp 0", halted); end
      step(); #1;
      n_vec++; if (halted !== 1'b1 || fault !== 1'b1 || if_valid !== 1'b0) begin
         n_err++; $display("FAIL fault_set: got h=%b f=%b v=%b exp 1 1 0", halted, fault, if_valid);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0; if_ready = 1'b1;
      step();
      redirect_valid = 1'b0;
      step(); step(); #1;
      n_vec++; if (halted !== 1'b1 || fault !== 1'b1 || if_valid !== 1'b0) begin
         n_err++; $display("FAIL halt_hold: got h=%b f=%b v=%b exp 1 1 0", halted, fault, if_valid);
      end
      if_ready = 1'b0;
      to_load(); #1;
      n_vec++; if (ld_ready !== 1'b1 || fault !== 1'b0 || halted !== 1'b0) begin
         n_err++; $display("FAIL halt_exit: got r=%b f=%b h=%b exp 1 0 0", ld_ready, fault, halted);
      end
   endtask

   task automatic test_overrun();
      logic [31:0] exp_pc;
      start_run();
      redirect_valid = 1'b1; redirect_pc = 32'h180;
      step();
      redirect_valid = 1'b0; exp_pc = 32'h180;
      for (int c = 0; c < 400; c++) begin
         if_ready = $urandom_range(0, 1) == 1;
         #1;
         if (if_valid) begin
            n_vec++; if (if_pc > 32'h1FC) begin n_err++; $display("FAIL overrun_pc: got %h exp <= 1fc", if_pc); end
         end
         if (if_valid && if_ready) begin
            n_vec++; if (if_pc !== exp_pc || if_instr !== mref[exp_pc[8:2]]) begin
               n_err++; $display("FAIL overrun_seq: got %h/%h exp %h/%h", if_pc, if_instr, exp_pc, mref[exp_pc[8:2]]);
            end
            exp_pc += 32'd4;
         end
         if (halted && !if_valid) break;
         step();
      end
      n_vec++; if (exp_pc !== 32'h200 || halted !== 1'b1 || fault !== 1'b1) begin
         n_err++; $display("FAIL overrun_end: got pc=%h h=%b f=%b exp 200 1 1", exp_pc, halted, fault);
      end
      if_ready = 1'b0;
      to_load();
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, prev_pc, prev_instr;
      logic        prev_valid, prev_ready, prev_redir;
      exp_pc = 32'h0; prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0;
      prev_pc = 32'h0; prev_instr = 32'h0;
      start_run();
      for (int c = 0; c < 400; c++) begin
         if_ready = $urandom_range(0, 2) != 0;
         redirect_valid = exp_pc >= 32'h180 || $urandom_range(0, 9) == 0;
         redirect_pc = $urandom_range(0, 32'h100) & 32'hFFFF_FFFC;
         #1;
         if (prev_redir) begin
            n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rand_bubble: got %b exp 0", if_valid); end
         end else if (prev_valid && !prev_ready) begin
            n_vec++; if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
               n_err++; $display("FAIL rand_stable: got v=%b %h/%h exp 1 %h/%h", if_valid, if_pc, if_instr, prev_pc, prev_instr);
            end
         end
         if (if_valid && if_ready) begin
            n_vec++; if (if_pc !== exp_pc || if_instr !== mref[exp_pc[8:2]]) begin
               n_err++; $display("FAIL rand_seq: got %h/%h exp %h/%h", if_pc, if_instr, exp_pc, mref[exp_pc[8:2]]);
            end
            exp_pc += 32'd4;
         end
         if (redirect_valid) exp_pc = redirect_pc;
         prev_valid = if_valid; prev_ready = if_ready; prev_redir = redirect_valid;
         prev_pc = if_pc; prev_instr = if_instr;
         step();
      end
      redirect_valid = 1'b0;
      #1;
      n_vec++; if (halted !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL rand_nofault: got h=%b f=%b exp 0 0", halted, fault); end
   endtask

   task automatic test_reset_mid();
      if_ready = 1'b0; redirect_valid = 1'b0;
      step(); step(); step(); #1;
      n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b exp 1", if_valid); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; #1;
      n_vec++; if (if_valid !== 1'b0 || ld_ready !== 1'b1 || halted !== 1'b0 || if_pc !== 32'h0) begin
         n_err++; $display("FAIL mid_reset: got v=%b r=%b h=%b pc=%h exp 0 1 0 0", if_valid, ld_ready, halted, if_pc);
      end
   endtask

   initial begin
      rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
      ld_done = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      test_reset();
      test_load();
      test_run_seq();
      test_stall();
      test_redirect();
      test_fault();
      test_overrun();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
